ram_param: RTL and testbench

Parametrised single-port synchronous RAM; successor to the fixed 2-word × 8-bit RAM cell used in the memory exercises. Adds:
- configurable word width and depth;
- registered read with a one-cycle `valid` strobe;
- out-of-range address detection;
- a self-timed `init` sweep that zeroes the whole array without asserting reset.

It sits between the test/CPU datapath and the storage layer.

---
 rtl/ram_param_if.sv | 26 ++
 rtl/ram_param.sv | 125 ++++++++++++
 tb/tb_ram_param.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_param_if.sv
// Access bus of the parametrised single-port RAM: request, write data and init
// from the datapath side; registered read data and status strobes back.
interface ram_param_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              en;
  logic              r_w;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data_in;
  logic              init;
  logic [WIDTH-1:0]  data_out;
  logic              valid;
  logic              err;
  logic              busy;

  modport master (
    output en, r_w, addr, data_in, init,
    input  data_out, valid, err, busy
  );

  modport slave (
    input  en, r_w, addr, data_in, init,
    output data_out, valid, err, busy
  );
endinterface

// File: rtl/ram_param.sv
// Single-port synchronous RAM with registered read, out-of-range flagging and
// a self-timed sweep that zeroes every word one per clock.
module ram_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic       clk,
  input  logic       clear,
  ram_param_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rd_word;
  logic              addr_oor;

  logic [WIDTH-1:0]  word_q [DEPTH];

  // Storage is plain registers: reset has to clear every word at once.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
        word_q[gi] <= '0;
      end else if (we && (waddr == ADDR_W'(gi))) begin
        word_q[gi] <= wdata;
      end
    end
  end

  // Out-of-range addresses match no word, so the mux yields zero for them.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, bus.addr} == (ADDR_W + 1)'(i)) begin
        rd_word = word_q[i];
      end
    end
  end

  assign addr_oor = ({1'b0, bus.addr} >= DEPTH_X);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    we         = 1'b0;
    waddr      = bus.addr;
    wdata      = bus.data_in;

    case (state_q)
      IDLE: begin
        if (bus.init) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (bus.en) begin
          if (addr_oor) begin
            err_d = 1'b1;
            if (!bus.r_w) begin
              valid_d    = 1'b1;
              data_out_d = '0;
            end
          end else if (bus.r_w) begin
            we = 1'b1;
          end else begin
            valid_d    = 1'b1;
            data_out_d = rd_word;
          end
        end
      end
      SWEEP: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q == SWEEP);

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: a 8x6 instance driven against a behavioural model with
// a scoreboard queue, plus a 16x8 instance for the generic-width case.
module tb_ram_param;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  ram_param_if #(.WIDTH(8),  .ADDR_W(3)) bus_a ();
  ram_param_if #(.WIDTH(16), .ADDR_W(3)) bus_b ();

  ram_param #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut_a (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_a.slave)
  );

  ram_param #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut_b (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic [15:0] dout;
    logic        valid;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Behavioural reference for the 8x6 instance.
  logic [7:0] m_mem [6];
  logic [7:0] m_dout;
  logic       m_busy;
  int         m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_mem[i] = 8'h00;
    m_dout = 8'h00;
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // Called at a falling edge: drive, predict, push; then sample after the
  // rising edge, pop and compare; return at the next falling edge.
  task automatic drive_a(input string tag, input logic en, input logic rw,
                         input logic [2:0] a, input logic [7:0] d, input logic ini);
    exp_t e;
    bus_a.en = en; bus_a.r_w = rw; bus_a.addr = a; bus_a.data_in = d; bus_a.init = ini;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (m_busy) begin
      m_mem[m_cnt] = 8'h00;
      if (m_cnt == 5) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else if (ini) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (en) begin
      if (a >= 3'd6) begin
        e.err = 1'b1;
        if (!rw) begin
          e.valid = 1'b1;
          m_dout  = 8'h00;
        end
      end else if (rw) begin
        m_mem[a] = d;
      end else begin
        e.valid = 1'b1;
        m_dout  = m_mem[a];
      end
    end
    e.dout = {8'h00, m_dout};
    e.busy = m_busy;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("A %-10s en=%0b rw=%0b addr=%0d din=%02h init=%0b | dout=%02h valid=%0b err=%0b busy=%0b",
             tag, en, rw, a, d, ini, bus_a.data_out, bus_a.valid, bus_a.err, bus_a.busy);
    check_eq({tag, ".dout"},  {24'h0, bus_a.data_out}, {16'h0, e.dout});
    check_eq({tag, ".valid"}, {31'h0, bus_a.valid},    {31'h0, e.valid});
    check_eq({tag, ".err"},   {31'h0, bus_a.err},      {31'h0, e.err});
    check_eq({tag, ".busy"},  {31'h0, bus_a.busy},     {31'h0, e.busy});
    @(negedge clk);
  endtask

  task automatic drive_b(input string tag, input logic en, input logic rw, input logic [2:0] a,
                         input logic [15:0] d, input logic [15:0] exp_dout, input logic exp_valid);
    exp_t e;
    bus_b.en = en; bus_b.r_w = rw; bus_b.addr = a; bus_b.data_in = d; bus_b.init = 1'b0;
    e.dout = exp_dout; e.valid = exp_valid; e.err = 1'b0; e.busy = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("B %-10s en=%0b rw=%0b addr=%0d din=%04h | dout=%04h valid=%0b err=%0b",
             tag, en, rw, a, d, bus_b.data_out, bus_b.valid, bus_b.err);
    check_eq({tag, ".dout"},  {16'h0, bus_b.data_out}, {16'h0, e.dout});
    check_eq({tag, ".valid"}, {31'h0, bus_b.valid},    {31'h0, e.valid});
    check_eq({tag, ".err"},   {31'h0, bus_b.err},      {31'h0, e.err});
    @(negedge clk);
  endtask

  task automatic idle_a(input string tag);
    drive_a(tag, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle_a(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (!bus_a.busy) break;
      idle_a(tag);
    end
    check_eq({tag, ".done"}, {31'h0, bus_a.busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_a.en = 1'b0; bus_a.r_w = 1'b0; bus_a.addr = '0; bus_a.data_in = '0; bus_a.init = 1'b0;
    bus_b.en = 1'b0; bus_b.r_w = 1'b0; bus_b.addr = '0; bus_b.data_in = '0; bus_b.init = 1'b0;
    model_reset();
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.dout",  {24'h0, bus_a.data_out}, 32'h0);
    check_eq("rst.valid", {31'h0, bus_a.valid},    32'h0);
    check_eq("rst.err",   {31'h0, bus_a.err},      32'h0);
    check_eq("rst.busy",  {31'h0, bus_a.busy},     32'h0);
    clear = 1'b1;

    // Basic write/read with output hold
    drive_a("s1_wr0", 1'b1, 1'b1, 3'd0, 8'hA5, 1'b0);
    drive_a("s1_wr5", 1'b1, 1'b1, 3'd5, 8'h5A, 1'b0);
    drive_a("s1_rd0", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    check_eq("s1_rd0_val", {24'h0, bus_a.data_out}, 32'hA5);
    idle_a("s1_hold0");
    drive_a("s1_rd5", 1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    check_eq("s1_rd5_val", {24'h0, bus_a.data_out}, 32'h5A);
    idle_a("s1_hold5");

    // Out-of-range
    drive_a("s2_wr6", 1'b1, 1'b1, 3'd6, 8'hFF, 1'b0);
    drive_a("s2_rd6", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
    check_eq("s2_rd6_err", {31'h0, bus_a.err}, 32'h1);
    drive_a("s2_rd7", 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    drive_a("s2_rd0", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    check_eq("s2_rd0_val", {24'h0, bus_a.data_out}, 32'hA5);

    // Init sweep with a colliding write
    for (int i = 0; i < 6; i++) drive_a("s3_fill", 1'b1, 1'b1, 3'(i), 8'(8'h10 + i), 1'b0);
    drive_a("s3_init", 1'b1, 1'b1, 3'd1, 8'h99, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus_a.busy) break;
      n++;
      idle_a("s3_sweep");
    end
    check_eq("s3_busy_len", n, 6);
    for (int i = 0; i < 6; i++) begin
      drive_a("s3_rd", 1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
      check_eq("s3_zero", {24'h0, bus_a.data_out}, 32'h0);
    end

    // Accesses while busy are ignored
    drive_a("s4_wr2", 1'b1, 1'b1, 3'd2, 8'h44, 1'b0);
    drive_a("s4_init", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    idle_a("s4_sweep");
    idle_a("s4_sweep");
    drive_a("s4_bwr2", 1'b1, 1'b1, 3'd2, 8'h33, 1'b0);
    drive_a("s4_brd7", 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    wait_idle_a("s4_wait");
    drive_a("s4_rd2", 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    check_eq("s4_rd2_val", {24'h0, bus_a.data_out}, 32'h0);

    // init held high: back-to-back sweeps
    drive_a("hold_wr0", 1'b1, 1'b1, 3'd0, 8'h55, 1'b0);
    for (int k = 0; k < 14; k++) drive_a("hold_init", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    wait_idle_a("hold_wait");

    // Asynchronous reset in the middle of a sweep
    drive_a("s5_wr4", 1'b1, 1'b1, 3'd4, 8'h77, 1'b0);
    drive_a("s5_rd4", 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    drive_a("s5_init", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    idle_a("s5_sweep");
    idle_a("s5_sweep");
    #2 clear = 1'b0;
    #1;
    check_eq("s5_async.busy",  {31'h0, bus_a.busy},     32'h0);
    check_eq("s5_async.dout",  {24'h0, bus_a.data_out}, 32'h0);
    check_eq("s5_async.valid", {31'h0, bus_a.valid},    32'h0);
    model_reset();
    @(negedge clk);
    clear = 1'b1;
    drive_a("s5_wr3", 1'b1, 1'b1, 3'd3, 8'h11, 1'b0);
    drive_a("s5_rd3", 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    check_eq("s5_rd3_val", {24'h0, bus_a.data_out}, 32'h11);
    for (int i = 0; i < 6; i++) begin
      if (i != 3) begin
        drive_a("s5_rd", 1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
        check_eq("s5_zero", {24'h0, bus_a.data_out}, 32'h0);
      end
    end

    // Generic width on the 16x8 instance
    drive_b("s6_wr7", 1'b1, 1'b1, 3'd7, 16'hBEEF, 16'h0000, 1'b0);
    drive_b("s6_rd7", 1'b1, 1'b0, 3'd7, 16'h0000, 16'hBEEF, 1'b1);
    drive_b("s6_hold", 1'b0, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
